// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: owns the PC, drives a synchronous instruction ROM,
// resolves relative jumps through a writable 16-entry offset LUT and detects halt.
module instr_fetch #(
    parameter int unsigned PC_W      = 10,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      mach_code,
    output logic            instr_valid,
    output logic [PC_W-1:0] cur_pc,
    input  logic            relj,
    input  logic            lut_we,
    input  logic [3:0]      lut_idx,
    input  logic [7:0]      lut_data,
    output logic            done
);

    localparam int unsigned OFF_W = 8;
    localparam int unsigned LUT_N = 16;
    localparam int unsigned EXT_W = PC_W - OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [PC_W-1:0]   imem_addr_q;
    logic [PC_W-1:0]   cur_pc_q;
    logic              instr_valid_q;
    logic              done_q;
    logic [OFF_W-1:0]  lut_q [LUT_N];

    logic              is_halt_c;
    logic [OFF_W-1:0]  offset_c;
    logic [PC_W-1:0]   target_c;
    logic [PC_W-1:0]   addr_inc_c;

    // Branch target uses the LUT value before any write landing on this same edge.
    always_comb begin
        is_halt_c  = instr_valid_q && (imem_data == HALT_WORD);
        offset_c   = lut_q[imem_data[3:0]];
        target_c   = cur_pc_q + {{EXT_W{offset_c[OFF_W-1]}}, offset_c};
        addr_inc_c = imem_addr_q + PC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_idx] <= lut_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            imem_addr_q   <= '0;
            cur_pc_q      <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done_q      <= 1'b0;
                        imem_addr_q <= '0;
                        state_q     <= S_FILL;
                    end
                end
                // FILL and FLUSH both complete a fetch whose address is in imem_addr_q.
                S_FILL, S_FLUSH: begin
                    cur_pc_q      <= imem_addr_q;
                    imem_addr_q   <= addr_inc_c;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_RUN;
                end
                S_RUN: begin
                    if (is_halt_c) begin
                        done_q        <= 1'b1;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_DONE;
                    end else if (instr_valid_q && relj) begin
                        imem_addr_q   <= target_c;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_FLUSH;
                    end else begin
                        cur_pc_q    <= imem_addr_q;
                        imem_addr_q <= addr_inc_c;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = imem_addr_q;
    assign cur_pc      = cur_pc_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign mach_code   = instr_valid_q ? imem_data : 9'h000;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a program-walk model builds the expected
// per-cycle trace (valid, pc, code, done) from ROM, LUT and branch decisions.
module tb_instr_fetch;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned DEPTH = 1 << PC_W;
    localparam logic [8:0]  HALT  = 9'h1FF;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [8:0]      mach_code;
    logic            instr_valid;
    logic [PC_W-1:0] cur_pc;
    logic            relj;
    logic            lut_we;
    logic [3:0]      lut_idx;
    logic [7:0]      lut_data;
    logic            done;

    instr_fetch #(.PC_W(PC_W), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .mach_code(mach_code), .instr_valid(instr_valid), .cur_pc(cur_pc),
        .relj(relj), .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] rom [DEPTH];
    always @(posedge clk) imem_data <= rom[imem_addr];

    typedef struct {
        bit              v;
        bit              d;
        logic [PC_W-1:0] pc;
        logic [8:0]      code;
        logic [PC_W-1:0] addr;
        int              k;
    } ent_t;

    ent_t       tr [$];
    bit         taken [256];
    logic [7:0] mlut [16];
    int         checks = 0;
    int         failures = 0;

    // Walk the program as an architect would: one cycle per instruction,
    // one extra bubble after a taken branch, FILL bubble up front.
    function automatic void build(input int maxlen);
        logic [PC_W-1:0] pc;
        logic [8:0]      code;
        int              k;
        ent_t            e;
        tr.delete();
        e = '{v: 0, d: 0, pc: '0, code: '0, addr: '0, k: -1};
        tr.push_back(e);
        pc = '0;
        k  = 0;
        while (tr.size() < maxlen) begin
            code = rom[pc];
            e = '{v: 1, d: 0, pc: pc, code: code, addr: '0, k: k};
            tr.push_back(e);
            if (code == HALT) begin
                e = '{v: 0, d: 1, pc: '0, code: '0, addr: pc + 10'd1, k: -1};
                tr.push_back(e);
                break;
            end
            if (taken[k]) begin
                e = '{v: 0, d: 0, pc: '0, code: '0, addr: '0, k: -1};
                tr.push_back(e);
                pc = pc + 10'($signed(mlut[code[3:0]]));
            end else begin
                pc = pc + 10'd1;
            end
            k++;
        end
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < DEPTH; a++) rom[a] = 9'h000;
        for (int k = 0; k < 256; k++) taken[k] = 1'b0;
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        lut_we = 1'b1; lut_idx = idx; lut_data = data;
        @(negedge clk);
        lut_we = 1'b0;
        mlut[idx] = data;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s valid got %b want 0", tag, instr_valid); end
        if (mach_code !== 9'h000) begin failures++; $display("FAIL %s mach_code got %h want 000", tag, mach_code); end
        if (cur_pc !== '0) begin failures++; $display("FAIL %s cur_pc got %0d want 0", tag, cur_pc); end
        if (imem_addr !== '0) begin failures++; $display("FAIL %s imem_addr got %0d want 0", tag, imem_addr); end
        if (done !== 1'b0) begin failures++; $display("FAIL %s done got %b want 0", tag, done); end
        for (int i = 0; i < 16; i++) mlut[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start the program and compare every cycle of the expected trace.
    task automatic run(input string tag, input int maxlen, input int stop_at, input int wr_k,
                       input logic [3:0] wr_idx, input logic [7:0] wr_data, input bit relj_bubble);
        int n;
        build(maxlen);
        n = (stop_at < tr.size()) ? stop_at : tr.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start  = (tr[i].d || i == n - 1) ? 1'b0 : 1'($urandom % 2);
            relj   = tr[i].v ? taken[tr[i].k] : (relj_bubble ? 1'b1 : 1'($urandom % 2));
            lut_we = (tr[i].v && tr[i].k == wr_k);
            lut_idx = wr_idx; lut_data = wr_data;
            checks += 3;
            if (instr_valid !== 1'(tr[i].v)) begin failures++;
                $display("FAIL %s[%0d] valid got %b want %b", tag, i, instr_valid, tr[i].v); end
            if (mach_code !== (tr[i].v ? tr[i].code : 9'h000)) begin failures++;
                $display("FAIL %s[%0d] mach_code got %h want %h", tag, i, mach_code, tr[i].code); end
            if (done !== 1'(tr[i].d)) begin failures++;
                $display("FAIL %s[%0d] done got %b want %b", tag, i, done, tr[i].d); end
            if (tr[i].v) begin
                checks++;
                if (cur_pc !== tr[i].pc) begin failures++;
                    $display("FAIL %s[%0d] cur_pc got %0d want %0d", tag, i, cur_pc, tr[i].pc); end
            end
            if (tr[i].d) begin
                checks++;
                if (imem_addr !== tr[i].addr) begin failures++;
                    $display("FAIL %s[%0d] imem_addr got %0d want %0d", tag, i, imem_addr, tr[i].addr); end
            end
        end
        @(negedge clk);
        start = 1'b0; relj = 1'b0; lut_we = 1'b0;
        if (wr_k >= 0) mlut[wr_idx] = wr_data;
        if (n == tr.size() && tr[n-1].d) begin
            @(negedge clk);
            checks += 3;
            if (done !== 1'b1) begin failures++; $display("FAIL %s hold done got %b want 1", tag, done); end
            if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s hold valid got %b want 0", tag, instr_valid); end
            if (imem_addr !== tr[n-1].addr) begin failures++;
                $display("FAIL %s hold imem_addr got %0d want %0d", tag, imem_addr, tr[n-1].addr); end
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_straight();
        clear_rom();
        rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = HALT;
        run("straight", 200, 1000, -1, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic test_forward_branch();
        clear_rom();
        lut_write(4'd2, 8'h05);
        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h092;
        rom[4] = 9'h0EE; rom[8] = 9'h0AB; rom[9] = HALT;
        taken[3] = 1'b1;
        run("fwd_branch", 200, 1000, -1, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic test_backward_wrap();
        clear_rom();
        lut_write(4'd1, 8'hFC);
        rom[0] = 9'h0A0; rom[1] = 9'h0A0; rom[2] = 9'h091; rom[3] = HALT;
        rom[1022] = 9'h0A5; rom[1023] = 9'h0A6;
        taken[2] = 1'b1;
        run("back_wrap", 200, 1000, -1, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic test_precedence();
        clear_rom();
        lut_write(4'd2, 8'h03);
        rom[0] = 9'h0A0; rom[1] = 9'h0B2; rom[4] = HALT; rom[5] = 9'h0C0;
        taken[1] = 1'b1;
        taken[2] = 1'b1;
        run("precedence", 200, 1000, 1, 4'd2, 8'h10, 1'b1);
    endtask

    task automatic test_reset_flush();
        clear_rom();
        lut_write(4'd2, 8'h07);
        rom[0] = 9'h0A2; rom[1] = HALT;
        taken[0] = 1'b1;
        run("pre_flush", 200, 3, -1, 4'd0, 8'd0, 1'b0);
        apply_reset("reset_flush");
        run("post_flush", 200, 1000, -1, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic test_restart();
        clear_rom();
        rom[0] = 9'h044; rom[1] = 9'h055; rom[2] = HALT;
        run("restart", 200, 1000, -1, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            apply_reset("rand_reset");
            for (int j = 0; j < 6; j++) lut_write(4'($urandom % 16), 8'($urandom));
            for (int a = 0; a < DEPTH; a++) rom[a] = 9'($urandom % 511);
            rom[$urandom_range(3, 40)] = HALT;
            for (int k = 0; k < 256; k++) taken[k] = ($urandom % 4 == 0);
            run("random", 80, 1000, -1, 4'd0, 8'd0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; relj = 1'b0;
        lut_we = 1'b0; lut_idx = 4'd0; lut_data = 8'd0;
        for (int i = 0; i < 16; i++) mlut[i] = 8'h00;
        clear_rom();
        repeat (2) @(posedge clk);
        test_reset();
        test_straight();
        test_forward_branch();
        test_backward_wrap();
        test_precedence();
        test_reset_flush();
        test_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing unit that produces the 9-bit `mach_code` stream consumed by the ALU/control datapath, and in turn consumes the ALU's `relj` branch-taken flag. It owns the program counter, addresses a synchronous instruction ROM, resolves relative jumps through a writable 16-entry signed-offset LUT, inserts one flush bubble per taken branch, and detects the halt word to signal program completion.

## Interface
- `PC_W`, 10, program counter / ROM address width; the ROM depth is 2^PC_W.
- `HALT_WORD`, 9'h1FF, instruction encoding that ends the program.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level-sampled request to begin execution at PC 0; only honoured in IDLE or DONE.
- `imem_addr`  out  PC_W  registered ROM address.
- `imem_data`  in  9  ROM read data; it equals mem[imem_addr sampled at the previous rising edge].
- `mach_code`  out  9  current instruction; `imem_data` when `instr_valid`=1, otherwise 9'h000.
- `instr_valid`  out  1  `mach_code` is a live instruction this cycle.
- `cur_pc`  out  PC_W  address of the instruction currently on `mach_code`.
- `relj`  in  1  branch taken, from the ALU, combinational in the same cycle as `mach_code`.
- `lut_we`  in  1  jump-LUT write enable.
- `lut_idx`  in  4  jump-LUT write index.
- `lut_data`  in  8  signed jump offset to write.
- `done`  out  1  the halt word has been executed; held until the next `start`.

## Operation
- **States:**
  - IDLE: reset state.
    - `imem_addr` holds 0 and `instr_valid`=0.
    - `start`=1 at an edge moves to FILL.
  - FILL: the ROM samples address 0.
    - Next edge: `imem_addr`←1, `cur_pc`←0, `instr_valid`←1, state RUN.
  - RUN: each edge with `instr_valid`=1, `relj`=0 and no halt: `cur_pc`←`imem_addr`, `imem_addr`←`imem_addr`+1.
  - Taken branch in RUN (`instr_valid`=1, `relj`=1, `mach_code`≠HALT_WORD):
    - Target = `cur_pc` + sign_extend(LUT[`mach_code`[3:0]]).
    - Edge: `imem_addr`←target, `instr_valid`←0, state FLUSH. The word fetched at this edge is discarded.
  - FLUSH: ROM samples target.
    - Next edge: `cur_pc`←target, `imem_addr`←target+1, `instr_valid`←1, state RUN.
  - Halt (`instr_valid`=1 and `mach_code`==HALT_WORD in RUN):
    - Edge: `done`←1, `instr_valid`←0, state DONE.
    - `imem_addr` freezes.
  - DONE: `start`=1 clears `done`, sets `imem_addr`←0 and goes to FILL.
- **Arithmetic:**
  - All PC arithmetic is modulo 2^PC_W.
  - The 8-bit offset is sign-extended to PC_W bits, so the range is −128..+127.
  - Increment past 2^PC_W−1 wraps to 0. Targets wrap both ways.
- **LUT:**
  - 16×8 bits, all entries 0 at reset; a branch through an unwritten entry jumps to itself.
  - Written on the edge when `lut_we`=1.
  - A branch resolving in the same cycle as a write to its index uses the pre-write value.
- **Precedence:**
  - HALT_WORD wins over `relj`: no jump, halt taken.
  - `relj` is ignored whenever `instr_valid`=0, including FILL, FLUSH, IDLE and DONE.
  - `start` is ignored in FILL, RUN and FLUSH.
- **Reset:** `rst_n` low at any time, including mid-branch or in FLUSH, immediately forces:
  - state IDLE;
  - `imem_addr`=0, `cur_pc`=0;
  - `instr_valid`=0, so `mach_code`=9'h000;
  - `done`=0;
  - LUT cleared.

## Timing
- Reset values: `imem_addr` 0, `cur_pc` 0, `instr_valid` 0, `mach_code` 9'h000, `done` 0.
- Start latency: `start` sampled at edge E0 → FILL during E0–E1 → `instr_valid`=1 with mem[0] from E1.
- Sequential throughput: one instruction per cycle.
- Taken branch: exactly one bubble cycle (`instr_valid`=0), then the target instruction.
  - Branch instruction in cycle t, target instruction in cycle t+2.
- Not-taken branch: no bubble.
- `done` rises on the edge after the halt word is presented, then stays high.
- Outputs are registered except `mach_code`, which is a gated ROM output.

## Test plan
1. **Straight line.** ROM[0..3] = 9'h011, 9'h022, 9'h033, 9'h1FF; pulse `start`.
   - Required: `mach_code` sequence 011, 022, 033, 1FF on consecutive cycles.
   - Required: `done`=1 one cycle after 1FF; `imem_addr` frozen; `instr_valid`=0.
2. **Forward branch with bubble.** LUT[2]=8'h05; ROM[3]=9'h092 with `relj` forced 1 on it.
   - Required: one `instr_valid`=0 cycle.
   - Required: next `cur_pc`=8, `mach_code`=ROM[8]; ROM[4] never marked valid.
3. **Backward branch and wrap.**
   - LUT[1]=8'hFC at `cur_pc`=2 → target 2^PC_W−2 (1022).
   - Straight run from PC 1023 → next `cur_pc`=0.
4. **Precedence and corner cases.**
   - `relj`=1 on HALT_WORD → `done`=1, no jump.
   - `relj`=1 during FLUSH → ignored.
   - `lut_we` to index 2 in the cycle a branch uses index 2 → old offset used.
5. **Reset mid-operation.** Assert `rst_n` low in FLUSH.
   - Required: all outputs go to reset values immediately; the LUT reads 0.
   - Required: after release, a branch via index 2 targets `cur_pc`.
6. **Restart.** `start` in DONE.
   - Required: `done` clears and fetch resumes from address 0 with FILL latency.
   - Required: `start` asserted in RUN has no effect.
